ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the word-aligned PC loaded on reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, fixed at 2, meaning the number of fetch-buffer entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_a, output, 6 bits: instruction-memory word address, equal to pc[7:2], combinational from pc.
REQ-006 The block SHALL have port imem_rd, input, 32 bits: instruction word returned combinationally by instruction memory for imem_a.
REQ-007 The block SHALL have port cmd, output, 32 bits: instruction word at the buffer head, delivered to the decoder.
REQ-008 The block SHALL have port cmd_pc, output, 32 bits: byte address of cmd.
REQ-009 The block SHALL have port cmd_valid, output, 1 bit: high when cmd/cmd_pc are valid.
REQ-010 The block SHALL have port cmd_ready, input, 1 bit: decoder accepts the head entry.
REQ-011 The block SHALL have port redir_valid, input, 1 bit: branch/jump redirect request (BEQ/BNE taken, JR).
REQ-012 The block SHALL have port redir_pc, input, 32 bits: redirect target byte address.
REQ-013 The block SHALL have port pc, output, 32 bits: current fetch PC, registered.
REQ-014 The block SHALL have port redir_misalign, output, 1 bit: sticky flag set when a redirect target has redir_pc[1:0] != 0.

Function
REQ-015 pop SHALL be defined as cmd_valid & cmd_ready; push SHALL be defined as !redir_valid & (count < 2 | pop), where count is the buffer occupancy, 0..2.
REQ-016 On push, the block SHALL write {pc, imem_rd} at the buffer tail and SHALL update pc <= pc + 4 in the same edge, with modulo 2^32 wrap (32'hFFFF_FFFC -> 0).
REQ-017 cmd, cmd_pc and cmd_valid SHALL be driven from registered buffer state only; fetch-to-cmd_valid latency SHALL be exactly 1 cycle with an empty buffer.
REQ-018 cmd_valid SHALL equal (count != 0); cmd and cmd_pc SHALL be X-free copies of the head entry and SHALL hold stable while cmd_valid & !cmd_ready.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged, including at count == 2.
REQ-020 With count == 2 and no pop, the block SHALL NOT push, and pc SHALL hold.
REQ-021 A redirect SHALL take, on the same edge, the actions in REQ-022 to REQ-025.
REQ-022 On redirect, count SHALL be set to 0 and all entries discarded.
REQ-023 On redirect, pc SHALL be set to {redir_pc[31:2], 2'b00}.
REQ-024 On redirect, no push SHALL occur.
REQ-025 On redirect with redir_pc[1:0] != 0, redir_misalign SHALL be set to 1 and SHALL remain 1 until reset.
REQ-026 A redirect coinciding with a pop SHALL still take effect: the popped head is consumed and nothing else survives.
REQ-027 After a redirect, the first cmd_valid SHALL appear 2 edges after the redirect edge, with cmd_pc equal to the aligned target.
REQ-028 Back-to-back redirects SHALL each apply; only the last target SHALL be fetched.
REQ-029 Buffer read and write pointers SHALL be 1-bit and wrap modulo 2.
REQ-030 With cmd_ready held high and no redirect, the block SHALL sustain one instruction per cycle.

Reset
REQ-031 On rst_n low, the block SHALL immediately, without waiting for clk, set pc = RESET_PC, count = 0, cmd_valid = 0, and redir_misalign = 0.
REQ-032 On rst_n low, pointers SHALL be set to 0, and cmd and cmd_pc SHALL be set to 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-034 The first fetch after reset SHALL occur on the first rising clk edge with rst_n high.

Verification
REQ-035 Reset release, cmd_ready = 1, imem holding words W0..W3: cmd_valid rises after edge 1, then cmd = W0, W1, W2, W3 on consecutive cycles with cmd_pc = 0, 4, 8, 12.
REQ-036 Stall test: cmd_ready = 0 for 5 cycles after reset: count reaches 2, pc holds at 8, cmd holds W0/pc 0; after cmd_ready = 1, W0, W1, W2 follow with no gap or duplicate.
REQ-037 Redirect test: redir_valid = 1 with redir_pc = 32'h20 while count = 2: the buffered W0/W1 never reach the decoder, pc = 32'h20, and 2 edges later cmd_pc = 32'h20 with cmd = RAM[8].
REQ-038 Misaligned redirect test: redir_pc = 32'h0000_0013: pc = 32'h10, redir_misalign = 1 and sticky across later redirects, cleared only by rst_n.
REQ-039 Wrap test: RESET_PC = 32'hFFFF_FFF8, cmd_ready = 1: cmd_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, with imem_a = 3E, 3F, 00.
REQ-040 Async reset test: rst_n pulsed low between clock edges while count = 2: cmd_valid drops within the same timestep, before the next edge, and refetch restarts from RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: registered PC feeding a two-entry fetch buffer that
// delivers {pc, word} pairs to the decoder, with redirect and misalign tracking.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [5:0]  imem_a,
    input  logic [31:0] imem_rd,
    output logic [31:0] cmd,
    output logic [31:0] cmd_pc,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] pc,
    output logic        redir_misalign
);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        mis_q, mis_d;
    logic [31:0] ins_q [DEPTH];
    logic [31:0] ipc_q [DEPTH];
    logic        pop_s, push_s;

    assign cmd_valid      = (count_q != 2'd0);
    assign cmd            = ins_q[rd_ptr_q];
    assign cmd_pc         = ipc_q[rd_ptr_q];
    assign pc             = pc_q;
    assign imem_a         = pc_q[7:2];
    assign redir_misalign = mis_q;

    // A full buffer may still accept a fetch when the head leaves this cycle.
    assign pop_s  = cmd_valid & cmd_ready;
    assign push_s = !redir_valid & ((count_q < 2'd2) | pop_s);

    // Next-state for PC, occupancy, pointers and the sticky misalign flag.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mis_d    = mis_q;
        if (redir_valid) begin
            pc_d     = {redir_pc[31:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            mis_d    = mis_q | (redir_pc[1:0] != 2'b00);
        end else begin
            if (push_s) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State and buffer storage; entries are cleared on reset so cmd is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mis_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ins_q[i] <= 32'd0;
                ipc_q[i] <= 32'd0;
            end
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mis_q    <= mis_d;
            if (push_s) begin
                ins_q[wr_ptr_q] <= imem_rd;
                ipc_q[wr_ptr_q] <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based fetch model compared every cycle, plus
// directed literal checks; a second instance exercises PC wrap-around.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        cmd_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [5:0]  imem_a, imem_a1;
    logic [31:0] imem_rd, imem_rd1;
    logic [31:0] cmd, cmd_pc, pc, cmd1, cmd_pc1, pc1;
    logic        cmd_valid, cmd_valid1, mis, mis1;

    logic [31:0] mem [64];
    logic [63:0] mq [$];
    logic [31:0] mpc;
    logic        mmis;
    int          checks = 0;
    int          errors = 0;

    assign imem_rd  = mem[imem_a];
    assign imem_rd1 = mem[imem_a1];

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_a(imem_a), .imem_rd(imem_rd),
        .cmd(cmd), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .pc(pc), .redir_misalign(mis)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_a(imem_a1), .imem_rd(imem_rd1),
        .cmd(cmd1), .cmd_pc(cmd_pc1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .pc(pc1), .redir_misalign(mis1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] w(input int i);
        return 32'hC0DE_0000 + 32'(i * 17);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: queue of {pc, word} fetched into an at-most-two-deep buffer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc  = 32'h0000_0000;
            mmis = 1'b0;
        end else if (redir_valid) begin
            mq.delete();
            mpc = {redir_pc[31:2], 2'b00};
            if (redir_pc[1:0] != 2'b00) mmis = 1'b1;
        end else begin
            if (mq.size() != 0 && cmd_ready) void'(mq.pop_front());
            if (mq.size() < 2) begin
                mq.push_back({mpc, mem[mpc[7:2]]});
                mpc = mpc + 32'd4;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("cmd_pc", cmd_pc, mq[0][63:32]);
            chk("cmd", cmd, mq[0][31:0]);
        end
        chk("pc", pc, mpc);
        chk("imem_a", {26'd0, imem_a}, {26'd0, mpc[7:2]});
        chk("misalign", {31'd0, mis}, {31'd0, mmis});
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = w(i);
        rst_n       = 1'b0;
        cmd_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'd0;
        #1;
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_cmd", cmd, 32'd0);
        chk("rst_cmd_pc", cmd_pc, 32'd0);
        chk("rst_mis", {31'd0, mis}, 32'd0);
        tick();
        tick();

        // Streaming with ready high, plus wrap on the second instance.
        cmd_ready = 1'b1;
        rst_n     = 1'b1;
        chk("wrap_imem_a0", {26'd0, imem_a1}, 32'h3E);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stream_valid", {31'd0, cmd_valid}, 32'd1);
            chk("stream_cmd", cmd, w(k));
            chk("stream_pc", cmd_pc, 32'(4 * k));
            if (k < 3) chk("wrap_cmd_pc", cmd_pc1, 32'hFFFF_FFF8 + 32'(4 * k));
            if (k == 0) chk("wrap_imem_a1", {26'd0, imem_a1}, 32'h3F);
            if (k == 1) chk("wrap_imem_a2", {26'd0, imem_a1}, 32'h00);
        end

        // Stall: buffer fills, PC holds, head holds, then drains without gaps.
        cmd_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        chk("stall_pc", pc, 32'h8);
        chk("stall_cmd", cmd, w(0));
        chk("stall_cmd_pc", cmd_pc, 32'h0);
        cmd_ready = 1'b1;
        tick();
        chk("drain_w1", cmd, w(1));
        tick();
        chk("drain_w2", cmd, w(2));

        // Redirect while full.
        cmd_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        redir_valid = 1'b1;
        redir_pc    = 32'h20;
        tick();
        redir_valid = 1'b0;
        chk("redir_pc", pc, 32'h20);
        chk("redir_flush", {31'd0, cmd_valid}, 32'd0);
        tick();
        chk("redir_valid", {31'd0, cmd_valid}, 32'd1);
        chk("redir_cmd_pc", cmd_pc, 32'h20);
        chk("redir_cmd", cmd, w(8));

        // Redirect coinciding with a pop.
        cmd_ready   = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h80;
        tick();
        redir_valid = 1'b0;
        chk("redir_pop_flush", {31'd0, cmd_valid}, 32'd0);
        tick();
        chk("redir_pop_cmd", cmd, w(32));

        // Back-to-back redirects: only the last is fetched.
        redir_valid = 1'b1;
        redir_pc    = 32'h24;
        tick();
        redir_pc    = 32'h30;
        tick();
        redir_valid = 1'b0;
        tick();
        chk("b2b_cmd_pc", cmd_pc, 32'h30);
        chk("b2b_cmd", cmd, w(12));

        // Misaligned redirect is sticky until reset.
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_0013;
        tick();
        chk("mis_pc", pc, 32'h10);
        chk("mis_set", {31'd0, mis}, 32'd1);
        redir_pc = 32'h40;
        tick();
        redir_valid = 1'b0;
        tick();
        chk("mis_sticky", {31'd0, mis}, 32'd1);

        // Mixed ready pattern.
        for (int i = 0; i < 30; i++) begin
            cmd_ready = (i % 3 != 1);
            tick();
        end

        // Asynchronous reset between edges while full.
        cmd_ready = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, cmd_valid}, 32'd0);
        chk("async_pc", pc, 32'd0);
        chk("async_mis", {31'd0, mis}, 32'd0);
        tick();
        rst_n     = 1'b1;
        cmd_ready = 1'b1;
        tick();
        chk("refetch_pc", cmd_pc, 32'd0);
        chk("refetch_cmd", cmd, w(0));
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
